aes_byte_stream: RTL
====================

# aes_byte_stream

Byte-serial front/back end for the AES-128 core: it collects 16-byte key and text frames from a byte valid/ready stream, presents them as stable 128-bit words with a one-cycle start pulse, waits for the core's done flag, captures the result and serialises it back out as 16 bytes. It sits between the UART/host byte link and the AES core, owning all handshaking so the core sees only held inputs.

## Interface
Parameters:
- NBYTE, 16: bytes per frame (fixed for AES-128)
- TIMEOUT, 64: max cycles in WAIT before abort

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  reset; **one clock; reset is synchronous and active-high**
- i_Byte  in  8  input byte
- i_fByteValid  in  1  input byte valid
- o_fByteReady  out  1  block accepts a byte this cycle
- i_fKeyFrame  in  1  frame type; 1 = key frame; sampled with first byte of a frame
- i_fEnc  in  1  1 = encrypt, 0 = decrypt; sampled with first byte of a text frame
- o_Key  out  128  held key to core
- o_Text  out  128  held text to core
- o_fEnc  out  1  held mode to core
- o_fStart  out  1  one-cycle start pulse to core
- o_fCoreRstN  out  1  active-low core reset (forces core re-key)
- i_Data  in  128  core result
- i_fDone  in  1  core done flag; i_Data valid only in that cycle
- o_Byte  out  8  output byte
- o_fByteValid  out  1  output byte valid
- i_fByteReady  in  1  sink accepts output byte
- o_fKeyLoaded  out  1  a key frame has completed since reset
- o_fBusy  out  1  state ≠ RX
- o_fErr  out  1  one-cycle error pulse

## Operation
- States: RX, START, WAIT, TX.
- RX: o_fByteReady=1; a byte is accepted on a clock with valid&ready; 4-bit counter counts 0..15, wraps to 0 on 16th byte. First byte → bits [127:120], last → [7:0]. Frame type and i_fEnc latched on byte 0; later changes within the frame are ignored.
- Key frame done: o_Key updated, o_fKeyLoaded=1, o_fCoreRstN low for 2 cycles, stay RX.
- Text frame done with o_fKeyLoaded=1: o_Text/o_fEnc updated, → START. Without key: frame discarded, o_fErr pulse, stay RX.
- START: o_fStart=1 for exactly one cycle, → WAIT, watchdog cleared.
- WAIT: on i_fDone capture i_Data, → TX. If watchdog reaches TIMEOUT with no done: o_fErr pulse, o_fCoreRstN low 2 cycles, → RX, no output.
- TX: o_fByteValid=1, o_Byte = captured[127:120] first; shift on each valid&ready; after 16th transfer → RX. i_fDone outside WAIT ignored.
- o_Key, o_Text, o_fEnc change only at frame completion; stable through START/WAIT.
- Reset: state RX, counters 0, all 128-bit registers 0, o_fKeyLoaded=0, o_fStart=0, o_fByteValid=0, o_fErr=0, o_fBusy=0, o_fByteReady=0 during reset and 1 the first cycle after, o_fCoreRstN=0 during reset and 1 after. Reset mid-frame or mid-TX discards everything.

## Timing
- 16th input byte accepted at edge N → o_fStart=1 in cycle N+1 → WAIT from N+2.
- i_fDone high at edge M → o_fByteValid=1 in cycle M+1.
- Output: one byte per cycle with i_fByteReady held 1; back-pressure holds o_Byte stable.
- Last output byte transferred at edge T → o_fByteReady=1 in cycle T+1.
- No input accepted in START/WAIT/TX (o_fByteReady=0).
- o_fErr, o_fStart: single-cycle registered pulses.

## Structure
- Package aes_stream_pkg: state enum (RX, START, WAIT, TX), NBYTE, TIMEOUT default, counter widths.
- One sub-module: aes_byte_ser (128-bit load, byte shift-out with valid/ready, done flag).

## Test plan
- Key 000102..0F then encrypt text 00112233..EEFF (FIPS-197 C.1) → o_fStart pulse once, output bytes 69 C4 E0 D8 6A 7B 04 30 D8 CD B7 80 70 B4 C5 5A.
- Text frame before any key → no o_fStart, o_fErr one pulse, o_fByteReady stays 1.
- Output sink toggling i_fByteReady 1/0 → 16 bytes exact, none duplicated/dropped, o_Byte stable while stalled.
- Model core never asserts i_fDone → o_fErr at TIMEOUT=64 cycles after WAIT entry, o_fCoreRstN low 2 cycles, back to RX.
- Assert i_Rst after 7 input bytes → next 16 bytes form a fresh frame; o_fKeyLoaded=0.
- i_fKeyFrame toggled after byte 0 of key frame → treated as key frame; second key frame → o_Key updated, o_fCoreRstN low 2 cycles.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// rtl/aes_stream_pkg.sv - shared types and defaults for the AES byte-stream front end
package aes_stream_pkg;

  localparam int NBYTE_DEF   = 16;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W       = $clog2(NBYTE_DEF);
  localparam int WDOG_W      = $clog2(TIMEOUT_DEF + 1);

  typedef enum logic [1:0] {
    S_RX    = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_TX    = 2'd3
  } state_t;

endpackage

// File: rtl/aes_byte_stream_if.sv
// rtl/aes_byte_stream_if.sv - byte valid/ready links between host and the AES stream block
interface aes_byte_stream_if;

  logic [7:0] i_Byte;
  logic       i_fByteValid;
  logic       o_fByteReady;
  logic [7:0] o_Byte;
  logic       o_fByteValid;
  logic       i_fByteReady;

  modport slave (
    input  i_Byte, i_fByteValid, i_fByteReady,
    output o_fByteReady, o_Byte, o_fByteValid
  );

  modport master (
    output i_Byte, i_fByteValid, i_fByteReady,
    input  o_fByteReady, o_Byte, o_fByteValid
  );

endinterface

// File: rtl/aes_byte_stream_ser.sv
// rtl/aes_byte_stream_ser.sv - loads a result word and shifts it out MSB byte first
module aes_byte_ser
  import aes_stream_pkg::*;
#(
  parameter int NBYTE = NBYTE_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_fLoad,
  input  logic [8*NBYTE-1:0] i_Data,
  output logic [7:0]         o_Byte,
  output logic               o_fByteValid,
  input  logic               i_fByteReady,
  output logic               o_fDone
);

  localparam int W  = 8 * NBYTE;
  localparam int CW = $clog2(NBYTE);

  logic [W-1:0]  sh_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q;
  logic          xfer;

  assign xfer         = valid_q && i_fByteReady;
  assign o_fDone      = xfer && (cnt_q == CW'(NBYTE - 1));
  assign o_Byte       = sh_q[W-1 -: 8];
  assign o_fByteValid = valid_q;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (i_fLoad) begin
      sh_q    <= i_Data;
      cnt_q   <= '0;
      valid_q <= 1'b1;
    end else if (xfer) begin
      sh_q <= {sh_q[W-9:0], 8'h00};
      if (o_fDone) begin
        cnt_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_byte_stream.sv
// rtl/aes_byte_stream.sv - collects key/text frames, drives the AES core, returns the result as bytes
module aes_byte_stream
  import aes_stream_pkg::*;
#(
  parameter int NBYTE   = NBYTE_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  aes_byte_stream_if.slave   bs,
  input  logic               i_fKeyFrame,
  input  logic               i_fEnc,
  output logic [8*NBYTE-1:0] o_Key,
  output logic [8*NBYTE-1:0] o_Text,
  output logic               o_fEnc,
  output logic               o_fStart,
  output logic               o_fCoreRstN,
  input  logic [8*NBYTE-1:0] i_Data,
  input  logic               i_fDone,
  output logic               o_fKeyLoaded,
  output logic               o_fBusy,
  output logic               o_fErr
);

  localparam int W  = 8 * NBYTE;
  localparam int CW = $clog2(NBYTE);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] rx_cnt;
  logic [W-9:0]  rx_buf;
  logic [W-1:0]  frame;
  logic          fr_key, fr_enc, cur_key, cur_enc;
  logic [WW-1:0] wd_cnt;
  logic [1:0]    crst_cnt;
  logic          key_loaded_q, start_q, err_q;
  logic          accept, last_byte, key_done, text_go, text_err;
  logic          timeout, done_load, ser_done;

  assign bs.o_fByteReady = (state_q == S_RX) && !i_Rst;
  assign accept    = bs.i_fByteValid && bs.o_fByteReady;
  assign last_byte = accept && (rx_cnt == CW'(NBYTE - 1));
  // Frame attributes come from the first byte; later bytes use the latched copy.
  assign cur_key   = (rx_cnt == '0) ? i_fKeyFrame : fr_key;
  assign cur_enc   = (rx_cnt == '0) ? i_fEnc      : fr_enc;
  assign frame     = {rx_buf, bs.i_Byte};
  assign key_done  = last_byte && cur_key;
  assign text_go   = last_byte && !cur_key && key_loaded_q;
  assign text_err  = last_byte && !cur_key && !key_loaded_q;
  assign done_load = (state_q == S_WAIT) && i_fDone;
  assign timeout   = (state_q == S_WAIT) && !i_fDone && (wd_cnt == WW'(TIMEOUT - 1));

  assign o_fStart     = start_q;
  assign o_fErr       = err_q;
  assign o_fKeyLoaded = key_loaded_q;
  assign o_fBusy      = (state_q != S_RX);
  assign o_fCoreRstN  = !i_Rst && (crst_cnt == 2'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state_q <= S_RX;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RX:    if (text_go) state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  if (done_load) state_d = S_TX;
               else if (timeout) state_d = S_RX;
      S_TX:    if (ser_done) state_d = S_RX;
      default: state_d = S_RX;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rx_cnt       <= '0;
      rx_buf       <= '0;
      fr_key       <= 1'b0;
      fr_enc       <= 1'b0;
      wd_cnt       <= '0;
      crst_cnt     <= 2'd0;
      key_loaded_q <= 1'b0;
      start_q      <= 1'b0;
      err_q        <= 1'b0;
      o_Key        <= '0;
      o_Text       <= '0;
      o_fEnc       <= 1'b0;
    end else begin
      start_q <= text_go;
      err_q   <= text_err || timeout;
      if (key_done || timeout)  crst_cnt <= 2'd2;
      else if (crst_cnt != 2'd0) crst_cnt <= crst_cnt - 2'd1;
      if (accept) begin
        rx_buf <= frame[W-9:0];
        rx_cnt <= (rx_cnt == CW'(NBYTE - 1)) ? '0 : rx_cnt + 1'b1;
        if (rx_cnt == '0) begin
          fr_key <= i_fKeyFrame;
          fr_enc <= i_fEnc;
        end
      end
      if (key_done) begin
        o_Key        <= frame;
        key_loaded_q <= 1'b1;
      end
      if (text_go) begin
        o_Text <= frame;
        o_fEnc <= cur_enc;
      end
      wd_cnt <= (state_q == S_WAIT) ? wd_cnt + 1'b1 : '0;
    end
  end

  aes_byte_ser #(.NBYTE(NBYTE)) u_ser (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_fLoad      (done_load),
    .i_Data       (i_Data),
    .o_Byte       (bs.o_Byte),
    .o_fByteValid (bs.o_fByteValid),
    .i_fByteReady (bs.i_fByteReady),
    .o_fDone      (ser_done)
  );

endmodule
